// File: rtl/ct_mmu_dutlb_refill_ctrl.sv
// ct_mmu_dutlb_refill_ctrl
// Refill sequencer for the data micro-TLB. It arbitrates the two LSU miss
// ports, runs one jTLB lookup at a time, picks a victim entry and drives the
// one-hot entry update bus.
//
// Handshakes:
// - lsu_missN_vld is a level request that stays high until refill_done[N].
// - ctrl_jtlb_req stays high with a stable VPN until jtlb_ctrl_ack. The ack
//   may arrive in the same cycle the request first rises.
// - jtlb_ctrl_resp_vld is a one-cycle result strobe. It is sampled only in
//   WAIT or DRAIN and ignored in every other state.
//
// Optional build macro: CT_MMU_DUTLB_REFILL_TIMEOUT_EN adds an 8-bit watchdog
// on WAIT and DRAIN.
module ct_mmu_dutlb_refill_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int VPN_WIDTH = 27,
  parameter int PPN_WIDTH = 28,
  parameter int FLG_WIDTH = 14
) (
  input  logic                 utlb_entry_clk,
  input  logic                 cpurst_b,
  input  logic                 lsu_miss0_vld,
  input  logic [VPN_WIDTH-1:0] lsu_miss0_vpn,
  input  logic                 lsu_miss1_vld,
  input  logic [VPN_WIDTH-1:0] lsu_miss1_vpn,
  input  logic                 utlb_flush,
  input  logic [ENTRY_NUM-1:0] entry_vld,
  output logic                 ctrl_jtlb_req,
  output logic [VPN_WIDTH-1:0] ctrl_jtlb_vpn,
  input  logic                 jtlb_ctrl_ack,
  input  logic                 jtlb_ctrl_resp_vld,
  input  logic [PPN_WIDTH-1:0] jtlb_ctrl_resp_ppn,
  input  logic [FLG_WIDTH-1:0] jtlb_ctrl_resp_flg,
  input  logic                 jtlb_ctrl_resp_fault,
  output logic [ENTRY_NUM-1:0] utlb_entry_upd,
  output logic [VPN_WIDTH-1:0] utlb_upd_vpn,
  output logic [PPN_WIDTH-1:0] utlb_upd_ppn,
  output logic [FLG_WIDTH-1:0] utlb_upd_flg,
  output logic [1:0]           refill_done,
  output logic                 refill_fault,
  output logic                 refill_busy
);

  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [VPN_WIDTH-1:0] cap_vpn;
  logic [PPN_WIDTH-1:0] cap_ppn;
  logic [FLG_WIDTH-1:0] cap_flg;
  logic                 cap_port;
  logic                 last_port;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     victim_idx;
  logic                 all_vld;
  logic                 sel_port;
  logic                 capture;
  logic                 resp_cap;
  logic                 fin;
  logic                 fin_fault;
  logic                 rr_adv;
  logic                 write_en;
  logic                 wd_expired;

  assign all_vld  = &entry_vld;
  // When both ports miss, serve the port that was not served last time.
  assign sel_port = (lsu_miss0_vld && lsu_miss1_vld) ? ~last_port : (lsu_miss1_vld && !lsu_miss0_vld);
  assign write_en = (state == ST_WRITE) && !utlb_flush;

  // State register.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next state and control strobes. Flush overrides everything except DRAIN,
  // which must still absorb the response of the lookup it abandoned.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    resp_cap  = 1'b0;
    fin       = 1'b0;
    fin_fault = 1'b0;
    rr_adv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!utlb_flush && (lsu_miss0_vld || lsu_miss1_vld)) begin
          capture   = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (utlb_flush)         state_nxt = ST_IDLE;
        else if (jtlb_ctrl_ack) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (utlb_flush) begin
          state_nxt = jtlb_ctrl_resp_vld ? ST_IDLE : ST_DRAIN;
        end else if (jtlb_ctrl_resp_vld) begin
          if (jtlb_ctrl_resp_fault) begin
            fin       = 1'b1;
            fin_fault = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            resp_cap  = 1'b1;
            state_nxt = ST_WRITE;
          end
        end else if (wd_expired) begin
          fin       = 1'b1;
          fin_fault = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
        if (!utlb_flush) begin
          fin    = 1'b1;
          rr_adv = all_vld;
        end
      end
      ST_DRAIN: begin
        if (jtlb_ctrl_resp_vld || wd_expired) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Captured miss, lookup result, arbitration history and round-robin pointer.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cap_vpn   <= '0;
      cap_ppn   <= '0;
      cap_flg   <= '0;
      cap_port  <= 1'b0;
      last_port <= 1'b1;
      rr_ptr    <= '0;
    end else begin
      if (capture) begin
        cap_vpn   <= sel_port ? lsu_miss1_vpn : lsu_miss0_vpn;
        cap_port  <= sel_port;
        last_port <= sel_port;
      end
      if (resp_cap) begin
        cap_ppn <= jtlb_ctrl_resp_ppn;
        cap_flg <= jtlb_ctrl_resp_flg;
      end
      if (rr_adv) rr_ptr <= (rr_ptr == LAST_IDX) ? '0 : rr_ptr + 1'b1;
    end
  end

  // Victim: the lowest invalid entry if there is one, otherwise the round-robin pointer.
  always_comb begin
    victim_idx = rr_ptr;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!entry_vld[i]) victim_idx = IDX_W'(i);
    end
  end

  // Completion pulse. A same-VPN miss waiting on the other port is completed too.
  always_comb begin
    refill_done = 2'b00;
    if (fin) begin
      refill_done[cap_port] = 1'b1;
      if (cap_port && lsu_miss0_vld && (lsu_miss0_vpn == cap_vpn)) refill_done[0] = 1'b1;
      if (!cap_port && lsu_miss1_vld && (lsu_miss1_vpn == cap_vpn)) refill_done[1] = 1'b1;
    end
  end

  assign refill_fault   = fin_fault;
  assign refill_busy    = (state != ST_IDLE);
  assign ctrl_jtlb_req  = (state == ST_REQ) && !utlb_flush;
  assign ctrl_jtlb_vpn  = ctrl_jtlb_req ? cap_vpn : '0;
  assign utlb_entry_upd = write_en ? (ENTRY_NUM'(1) << victim_idx) : '0;
  assign utlb_upd_vpn   = write_en ? cap_vpn : '0;
  assign utlb_upd_ppn   = write_en ? cap_ppn : '0;
  assign utlb_upd_flg   = write_en ? cap_flg : '0;

`ifdef CT_MMU_DUTLB_REFILL_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog: cleared on each state change, counts cycles spent in WAIT or DRAIN.
  always_ff @(posedge utlb_entry_clk or negedge cpurst_b) begin
    if (!cpurst_b)                                  wd_cnt <= 8'd0;
    else if (state_nxt != state)                    wd_cnt <= 8'd0;
    else if (state == ST_WAIT || state == ST_DRAIN) wd_cnt <= wd_cnt + 8'd1;
  end

  assign wd_expired = (state == ST_WAIT || state == ST_DRAIN) && (wd_cnt == 8'hFF);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_ct_mmu_dutlb_refill_ctrl.sv
// Testbench for ct_mmu_dutlb_refill_ctrl: directed cases followed by
// randomized refill transactions. The expected refill outputs are queued
// when the stimulus is issued and popped by a monitor on every done or
// update cycle.
module tb_ct_mmu_dutlb_refill_ctrl;
  localparam int N  = 8;
  localparam int VW = 27;
  localparam int PW = 28;
  localparam int FW = 14;
  localparam int EW = 2 + 1 + N + VW + PW + FW;

  logic          utlb_entry_clk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          lsu_miss0_vld = 1'b0;
  logic [VW-1:0] lsu_miss0_vpn = '0;
  logic          lsu_miss1_vld = 1'b0;
  logic [VW-1:0] lsu_miss1_vpn = '0;
  logic          utlb_flush = 1'b0;
  logic [N-1:0]  entry_vld = '0;
  logic          ctrl_jtlb_req;
  logic [VW-1:0] ctrl_jtlb_vpn;
  logic          jtlb_ctrl_ack = 1'b0;
  logic          jtlb_ctrl_resp_vld = 1'b0;
  logic [PW-1:0] jtlb_ctrl_resp_ppn = '0;
  logic [FW-1:0] jtlb_ctrl_resp_flg = '0;
  logic          jtlb_ctrl_resp_fault = 1'b0;
  logic [N-1:0]  utlb_entry_upd;
  logic [VW-1:0] utlb_upd_vpn;
  logic [PW-1:0] utlb_upd_ppn;
  logic [FW-1:0] utlb_upd_flg;
  logic [1:0]    refill_done;
  logic          refill_fault;
  logic          refill_busy;

  ct_mmu_dutlb_refill_ctrl #(.ENTRY_NUM(N), .VPN_WIDTH(VW), .PPN_WIDTH(PW), .FLG_WIDTH(FW)) dut (
    .utlb_entry_clk      (utlb_entry_clk),
    .cpurst_b            (cpurst_b),
    .lsu_miss0_vld       (lsu_miss0_vld),
    .lsu_miss0_vpn       (lsu_miss0_vpn),
    .lsu_miss1_vld       (lsu_miss1_vld),
    .lsu_miss1_vpn       (lsu_miss1_vpn),
    .utlb_flush          (utlb_flush),
    .entry_vld           (entry_vld),
    .ctrl_jtlb_req       (ctrl_jtlb_req),
    .ctrl_jtlb_vpn       (ctrl_jtlb_vpn),
    .jtlb_ctrl_ack       (jtlb_ctrl_ack),
    .jtlb_ctrl_resp_vld  (jtlb_ctrl_resp_vld),
    .jtlb_ctrl_resp_ppn  (jtlb_ctrl_resp_ppn),
    .jtlb_ctrl_resp_flg  (jtlb_ctrl_resp_flg),
    .jtlb_ctrl_resp_fault(jtlb_ctrl_resp_fault),
    .utlb_entry_upd      (utlb_entry_upd),
    .utlb_upd_vpn        (utlb_upd_vpn),
    .utlb_upd_ppn        (utlb_upd_ppn),
    .utlb_upd_flg        (utlb_upd_flg),
    .refill_done         (refill_done),
    .refill_fault        (refill_fault),
    .refill_busy         (refill_busy)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 utlb_entry_clk = ~utlb_entry_clk;

  int cyc = 0;
  always @(posedge utlb_entry_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int last_done_cyc = -1;
  int txn_cyc = 0;

  // Reference model state: round-robin victim counter and last served port.
  int rr = 0;
  int last_port = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge utlb_entry_clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge utlb_entry_clk) begin
    logic [EW-1:0] act;
    if (cpurst_b && (refill_done != 2'b00 || utlb_entry_upd != '0)) begin
      last_done_cyc = cyc;
      act = {refill_done, refill_fault, utlb_entry_upd, utlb_upd_vpn, utlb_upd_ppn, utlb_upd_flg};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_refill: got %0h expected none", act);
      end else begin
        chk("refill_out", act, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    lsu_miss0_vld = 1'b0;
    lsu_miss1_vld = 1'b0;
    utlb_flush = 1'b0;
    jtlb_ctrl_ack = 1'b0;
    jtlb_ctrl_resp_vld = 1'b0;
    jtlb_ctrl_resp_fault = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {ctrl_jtlb_req, ctrl_jtlb_vpn, utlb_entry_upd, utlb_upd_vpn, utlb_upd_ppn,
               utlb_upd_flg, refill_done, refill_fault, refill_busy}, '0);
  endtask

  task automatic do_reset();
    cpurst_b = 1'b0;
    clear_inputs();
    repeat (2) step();
    check_outputs_zero("reset_outputs");
    rr = 0;
    last_port = 1;
    exp_q.delete();
    cpurst_b = 1'b1;
    step();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ctrl_jtlb_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // One miss scenario. flush_mode: 0 none, 1 flush in REQ, 2 flush in WAIT
  // with a late response, 3 flush together with the response, 4 flush in WRITE.
  task automatic do_txn(input logic [1:0] mask, input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                        input logic [N-1:0] ev, input int flush_mode, input bit fault,
                        input logic [PW-1:0] ppn, input logic [FW-1:0] flg,
                        input int ack_dly, input int rsp_dly);
    logic [1:0]    pend;
    logic [1:0]    d;
    logic [N-1:0]  u;
    logic [VW-1:0] vpn;
    logic [VW-1:0] vpn_o;
    int            port;
    int            vic;
    bit            ok;
    bit            fl_write;
    entry_vld = ev;
    lsu_miss0_vld = mask[0];
    lsu_miss0_vpn = v0;
    lsu_miss1_vld = mask[1];
    lsu_miss1_vpn = v1;
    pend = mask;
    txn_cyc = cyc;
    step();
    for (int s = 0; s < 2 && pend != 2'b00; s++) begin
      port = (pend == 2'b11) ? ((last_port == 1) ? 0 : 1) : (pend[0] ? 0 : 1);
      last_port = port;
      vpn   = (port == 1) ? v1 : v0;
      vpn_o = (port == 1) ? v0 : v1;
      wait_req(ok);
      chk("req_seen", ok, 1'b1);
      if (!ok) begin
        clear_inputs();
        return;
      end
      chk("req_vpn", ctrl_jtlb_vpn, vpn);
      if (s == 0 && flush_mode == 1) begin
        utlb_flush = 1'b1;
        lsu_miss0_vld = 1'b0;
        lsu_miss1_vld = 1'b0;
        #1;
        chk("req_withdrawn", ctrl_jtlb_req, 1'b0);
        step();
        utlb_flush = 1'b0;
        chk("idle_after_req_flush", {refill_busy, ctrl_jtlb_req}, 2'b00);
        return;
      end
      for (int a = 0; a < ack_dly; a++) begin
        step();
        chk("req_held", {ctrl_jtlb_req, ctrl_jtlb_vpn}, {1'b1, vpn});
      end
      jtlb_ctrl_ack = 1'b1;
      step();
      jtlb_ctrl_ack = 1'b0;
      if (s == 0 && flush_mode == 2) begin
        utlb_flush = 1'b1;
        lsu_miss0_vld = 1'b0;
        lsu_miss1_vld = 1'b0;
        step();
        utlb_flush = 1'b0;
        repeat (3) step();
        chk("drain_busy", refill_busy, 1'b1);
        jtlb_ctrl_resp_vld = 1'b1;
        jtlb_ctrl_resp_ppn = ppn;
        jtlb_ctrl_resp_flg = flg;
        step();
        jtlb_ctrl_resp_vld = 1'b0;
        chk("idle_after_drain", {refill_busy, ctrl_jtlb_req}, 2'b00);
        return;
      end
      repeat (rsp_dly) step();
      if (s == 0 && flush_mode == 3) begin
        utlb_flush = 1'b1;
        jtlb_ctrl_resp_vld = 1'b1;
        lsu_miss0_vld = 1'b0;
        lsu_miss1_vld = 1'b0;
        step();
        utlb_flush = 1'b0;
        jtlb_ctrl_resp_vld = 1'b0;
        chk("idle_after_resp_flush", {refill_busy, ctrl_jtlb_req}, 2'b00);
        return;
      end
      // Expected completion: served port plus a same-VPN miss on the other port.
      d = 2'b00;
      d[port] = 1'b1;
      if (pend[1 - port] && vpn_o == vpn) d[1 - port] = 1'b1;
      vic = -1;
      for (int i = 0; i < N; i++) if (!ev[i] && vic < 0) vic = i;
      if (vic < 0) vic = rr;
      u = '0;
      u[vic] = 1'b1;
      fl_write = (s == 0 && flush_mode == 4 && !fault);
      if (fault) exp_q.push_back({d, 1'b1, {N{1'b0}}, {VW{1'b0}}, {PW{1'b0}}, {FW{1'b0}}});
      else if (!fl_write) exp_q.push_back({d, 1'b0, u, vpn, ppn, flg});
      jtlb_ctrl_resp_vld = 1'b1;
      jtlb_ctrl_resp_fault = fault;
      jtlb_ctrl_resp_ppn = ppn;
      jtlb_ctrl_resp_flg = flg;
      step();
      jtlb_ctrl_resp_vld = 1'b0;
      jtlb_ctrl_resp_fault = 1'b0;
      if (fl_write) begin
        utlb_flush = 1'b1;
        lsu_miss0_vld = 1'b0;
        lsu_miss1_vld = 1'b0;
        step();
        utlb_flush = 1'b0;
        chk("idle_after_write_flush", {refill_busy, ctrl_jtlb_req}, 2'b00);
        return;
      end
      if (!fault) begin
        step();
        if (&ev) rr = (rr + 1) % N;
      end
      pend = pend & ~d;
      lsu_miss0_vld = pend[0];
      lsu_miss1_vld = pend[1];
    end
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Single miss at minimum latency.
    do_txn(2'b01, VW'('h12345), '0, '0, 0, 1'b0, PW'('hABCDE), FW'('h1F), 0, 0);
    chk("min_latency", last_done_cyc - txn_cyc, 3);

    // Both ports with different VPNs: port0 first after reset.
    do_reset();
    do_txn(2'b11, VW'(1), VW'(2), '0, 0, 1'b0, PW'('h111), FW'('h2), 0, 1);

    // Both ports with the same VPN: one lookup, merged completion.
    do_txn(2'b11, VW'('h77), VW'('h77), '0, 0, 1'b0, PW'('h777), FW'('h7), 1, 0);

    // All entries valid: round-robin victims wrap after ENTRY_NUM refills.
    do_reset();
    for (int k = 0; k < 9; k++)
      do_txn(2'b01, VW'($urandom), '0, '1, 0, 1'b0, PW'($urandom), FW'($urandom), 0, 0);

    // Flush in WAIT, late response drained, then a normal miss.
    do_txn(2'b01, VW'('h55), '0, '0, 2, 1'b0, PW'('h5), FW'('h5), 0, 0);
    do_txn(2'b10, VW'('h1), VW'('h66), 8'h0F, 0, 1'b0, PW'('h6), FW'('h6), 0, 0);

    // Fault response, then flushes in REQ, with the response, and in WRITE.
    do_txn(2'b01, VW'('h99), '0, '0, 0, 1'b1, PW'('h9), FW'('h9), 0, 2);
    do_txn(2'b01, VW'('h3), '0, '0, 1, 1'b0, PW'('h3), FW'('h3), 0, 0);
    do_txn(2'b10, VW'('h4), VW'('h4), '0, 3, 1'b0, PW'('h4), FW'('h4), 0, 0);
    do_txn(2'b01, VW'('h8), '0, '1, 4, 1'b0, PW'('h8), FW'('h8), 0, 0);
    do_txn(2'b01, VW'('h9), '0, '1, 0, 1'b0, PW'('h9), FW'('h9), 0, 0);

    // Randomized transactions.
    for (int k = 0; k < 150; k++) begin
      logic [1:0]    m;
      logic [VW-1:0] a;
      logic [VW-1:0] b;
      logic [N-1:0]  ev;
      int            fm;
      m  = 2'($urandom_range(1, 3));
      a  = VW'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : VW'($urandom);
      ev = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
      fm = $urandom_range(0, 9);
      if (fm > 4) fm = 0;
      do_txn(m, a, b, ev, fm, ($urandom_range(0, 7) == 0), PW'($urandom), FW'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in WAIT; the late response must be ignored.
    lsu_miss0_vld = 1'b1;
    lsu_miss0_vpn = VW'('h42);
    step();
    jtlb_ctrl_ack = 1'b1;
    step();
    jtlb_ctrl_ack = 1'b0;
    cpurst_b = 1'b0;
    lsu_miss0_vld = 1'b0;
    #1;
    check_outputs_zero("midop_reset_outputs");
    rr = 0;
    last_port = 1;
    step();
    cpurst_b = 1'b1;
    step();
    jtlb_ctrl_resp_vld = 1'b1;
    step();
    jtlb_ctrl_resp_vld = 1'b0;
    chk("late_resp_ignored", {refill_busy, ctrl_jtlb_req}, 2'b00);
    repeat (3) step();

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
